metal_hat_voice: RTL and testbench

METAL_HAT_VOICE -- requirements
Module: metal_hat_voice

---
 rtl/metal_hat_voice.sv | 168 ++++++++++++++++
 tb/tb_metal_hat_voice.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/metal_hat_voice.sv
// Metal hi-hat voice: LFSR noise, high-pass shaping, decay/choke envelope, 2-stage gain pipeline.
// Optional feature: define HAT_CHOKE_FADE_EN for a ramped choke fade instead of an instant cut.
module metal_hat_voice #(
  parameter int OUT_W       = 10,
  parameter int VEL_W       = 4,
  parameter int OPEN_RATE   = 6,
  parameter int CLOSED_RATE = 2,
  parameter int DECAY_STEP  = 1,
  parameter int FADE_STEP   = 16
) (
  input  logic             audio_tick,
  input  logic             reset,
  input  logic             trigger,
  input  logic             open_sel,
  input  logic [VEL_W-1:0] velocity,
  input  logic             choke,
  output logic [OUT_W-1:0] out,
  output logic             active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DECAY = 2'd1,
    FADE  = 2'd2
  } state_t;

  localparam int PRE_W = ((OPEN_RATE > CLOSED_RATE) ? OPEN_RATE : CLOSED_RATE) + 1;
  localparam logic [PRE_W-1:0] OPEN_WRAP   = PRE_W'((1 << OPEN_RATE) - 1);
  localparam logic [PRE_W-1:0] CLOSED_WRAP = PRE_W'((1 << CLOSED_RATE) - 1);
  localparam logic [15:0]      LFSR_SEED   = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS   = 16'hB400;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] s;
    s = {1'b0, v[15:1]};
    if (v[0]) begin
      s = s ^ LFSR_TAPS;
    end
    return s;
  endfunction

  // First difference removes the low end; subtracting hp/8 tilts the response, then clip to unsigned.
  function automatic logic [OUT_W-1:0] hp_clip(input logic [OUT_W-1:0] cur,
                                               input logic [OUT_W-1:0] prev);
    logic signed [OUT_W:0] hp;
    logic signed [OUT_W:0] bp;
    hp = $signed({1'b0, cur}) - $signed({1'b0, prev});
    bp = hp - (hp >>> 3);
    if (bp[OUT_W]) begin
      return '0;
    end
    return bp[OUT_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] sat_dec(input logic [OUT_W-1:0] g, input int step);
    if (int'(g) <= step) begin
      return '0;
    end
    return OUT_W'(int'(g) - step);
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [OUT_W-1:0]    prev_noise_q, prev_noise_d;
  logic [OUT_W-1:0]    gain_q, gain_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                mode_open_q, mode_open_d;
  logic [2*OUT_W-1:0]  mult_p1_q, mult_p1_d;
  logic [OUT_W-1:0]    out_p2_q, out_p2_d;

  logic [OUT_W-1:0]    noise;
  logic [OUT_W-1:0]    hat;
  logic [OUT_W-1:0]    gain_load;
  logic [OUT_W-1:0]    decay_val;
  logic [OUT_W-1:0]    fade_val;
  logic [PRE_W-1:0]    wrap_val;
  logic                trig_ok;
  logic                unused_mult_lsbs;

  assign noise     = lfsr_q[15 -: OUT_W];
  assign hat       = hp_clip(noise, prev_noise_q);
  // Velocity lands in the top bits; the remaining bits are filled with ones for a full-scale peak.
  assign gain_load = (OUT_W'(velocity) << (OUT_W - VEL_W)) | ({OUT_W{1'b1}} >> VEL_W);
  assign decay_val = sat_dec(gain_q, DECAY_STEP);
  assign fade_val  = sat_dec(gain_q, FADE_STEP);
  assign wrap_val  = mode_open_q ? OPEN_WRAP : CLOSED_WRAP;
  assign trig_ok   = trigger && (velocity != '0);

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    pre_d       = pre_q;
    mode_open_d = mode_open_q;
    if (trig_ok) begin
      state_d     = DECAY;
      gain_d      = gain_load;
      mode_open_d = open_sel;
      pre_d       = '0;
    end else begin
      case (state_q)
        DECAY: begin
          if (choke && mode_open_q) begin
`ifdef HAT_CHOKE_FADE_EN
            state_d = FADE;
`else
            state_d = IDLE;
            gain_d  = '0;
`endif
          end else if (pre_q == wrap_val) begin
            pre_d  = '0;
            gain_d = decay_val;
            if (decay_val == '0) begin
              state_d = IDLE;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        FADE: begin
          gain_d = fade_val;
          if (fade_val == '0) begin
            state_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    lfsr_d       = lfsr_next(lfsr_q);
    prev_noise_d = noise;
    // stage 1: shaped noise times envelope gain
    mult_p1_d    = {{OUT_W{1'b0}}, hat} * {{OUT_W{1'b0}}, gain_q};
    // stage 2: keep the upper half as the audio sample
    out_p2_d     = mult_p1_q[2*OUT_W-1:OUT_W];
  end

  assign unused_mult_lsbs = ^mult_p1_q[OUT_W-1:0];

  always_ff @(posedge audio_tick) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      prev_noise_q <= '0;
      gain_q       <= '0;
      pre_q        <= '0;
      mode_open_q  <= 1'b0;
      mult_p1_q    <= '0;
      out_p2_q     <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      prev_noise_q <= prev_noise_d;
      gain_q       <= gain_d;
      pre_q        <= pre_d;
      mode_open_q  <= mode_open_d;
      mult_p1_q    <= mult_p1_d;
      out_p2_q     <= out_p2_d;
    end
  end

  assign out    = out_p2_q;
  assign active = (state_q != IDLE);

endmodule

// File: tb/tb_metal_hat_voice.sv
// Self-checking bench for metal_hat_voice: directed envelope cases plus random stimulus vs a tick-level model.
module tb_metal_hat_voice;
  localparam int OUT_W       = 10;
  localparam int VEL_W       = 4;
  localparam int OPEN_RATE   = 6;
  localparam int CLOSED_RATE = 2;
  localparam int DECAY_STEP  = 1;
  localparam int FADE_STEP   = 16;

  logic             audio_tick = 1'b0;
  logic             reset = 1'b1;
  logic             trigger = 1'b0;
  logic             open_sel = 1'b0;
  logic [VEL_W-1:0] velocity = '0;
  logic             choke = 1'b0;
  logic [OUT_W-1:0] out;
  logic             active;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: envelope described as base - step * floor(ticks / period)
  int m_lfsr, m_prev, m_mult, m_out;
  int m_playing, m_fading, m_open;
  int m_base, m_ticks, m_period, m_stepsz;

  always #5 audio_tick = ~audio_tick;

  metal_hat_voice #(
    .OUT_W(OUT_W), .VEL_W(VEL_W), .OPEN_RATE(OPEN_RATE), .CLOSED_RATE(CLOSED_RATE),
    .DECAY_STEP(DECAY_STEP), .FADE_STEP(FADE_STEP)
  ) dut (
    .audio_tick(audio_tick), .reset(reset), .trigger(trigger), .open_sel(open_sel),
    .velocity(velocity), .choke(choke), .out(out), .active(active)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lfsr_adv(input int v);
    int r;
    r = v >> 1;
    if ((v & 1) != 0) r = r ^ 'hB400;
    return r & 'hFFFF;
  endfunction

  function automatic int floor_div8(input int x);
    if (x >= 0) return x / 8;
    return -((-x + 7) / 8);
  endfunction

  function automatic int model_hat(input int lf, input int pv);
    int hp, bp;
    hp = (lf >> (16 - OUT_W)) - pv;
    bp = hp - floor_div8(hp);
    return (bp < 0) ? 0 : bp;
  endfunction

  function automatic int m_gain();
    int g;
    if (m_playing == 0) return 0;
    g = m_base - m_stepsz * (m_ticks / m_period);
    return (g < 0) ? 0 : g;
  endfunction

  task automatic model_step(input bit rst, input bit trg, input bit opn, input int vel, input bit chk);
    int prod, g_now;
    if (rst) begin
      m_lfsr = 'hACE1; m_prev = 0; m_mult = 0; m_out = 0;
      m_playing = 0; m_fading = 0; m_base = 0; m_ticks = 0; m_period = 1; m_stepsz = 1;
      return;
    end
    g_now  = m_gain();
    prod   = model_hat(m_lfsr, m_prev) * g_now;
    m_out  = m_mult >> OUT_W;
    m_mult = prod;
    m_prev = m_lfsr >> (16 - OUT_W);
    m_lfsr = lfsr_adv(m_lfsr);
    if (trg && vel != 0) begin
      m_playing = 1; m_fading = 0; m_open = opn; m_ticks = 0;
      m_base    = (vel << (OUT_W - VEL_W)) | ((1 << (OUT_W - VEL_W)) - 1);
      m_period  = 1 << (opn ? OPEN_RATE : CLOSED_RATE);
      m_stepsz  = DECAY_STEP;
    end else if (m_playing != 0 && m_fading == 0 && m_open != 0 && chk) begin
`ifdef HAT_CHOKE_FADE_EN
      m_fading = 1; m_base = g_now; m_ticks = 0; m_period = 1; m_stepsz = FADE_STEP;
`else
      m_playing = 0;
`endif
    end else if (m_playing != 0) begin
      m_ticks++;
      if (m_base - m_stepsz * (m_ticks / m_period) <= 0) m_playing = 0;
    end
  endtask

  task automatic tick(input bit rst, input bit trg, input bit opn, input int vel, input bit chk);
    reset    = rst;
    trigger  = trg;
    open_sel = opn;
    velocity = VEL_W'(vel);
    choke    = chk;
    model_step(rst, trg, opn, vel, chk);
    @(posedge audio_tick);
    #1;
    check_eq("out", int'(out), m_out);
    check_eq("active", int'(active), m_playing);
    check_eq("gain", int'(dut.gain_q), m_gain());
  endtask

  initial begin
    int n;
    int exp_choke_len;

    // Reset state
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_eq("rst_lfsr", int'(dut.lfsr_q), 'hACE1);
    check_eq("rst_out", int'(out), 0);
    check_eq("rst_active", int'(active), 0);
    repeat (5) tick(0, 0, 0, 0, 0);

    // Closed decay: full length, random chokes must be ignored
    tick(0, 1, 0, 15, 0);
    check_eq("closed_peak", int'(dut.gain_q), 1023);
    n = 0;
    while (active && n < 5000) begin
      tick(0, 0, $urandom_range(0, 1), 0, $urandom_range(0, 1));
      n++;
    end
    check_eq("closed_len", n, 4092);
    repeat (4) tick(0, 0, 0, 0, 0);
    check_eq("closed_out_zero", int'(out), 0);

    // Open decay: one step every 64 ticks
    tick(0, 1, 1, 15, 0);
    check_eq("open_peak", int'(dut.gain_q), 1023);
    repeat (63) tick(0, 0, 0, 0, 0);
    check_eq("open_hold", int'(dut.gain_q), 1023);
    tick(0, 0, 0, 0, 0);
    check_eq("open_step", int'(dut.gain_q), 1022);
    repeat (200) tick(0, 0, 0, 0, 0);

    // Choke of an open note at full gain
    tick(0, 1, 1, 15, 0);
    tick(0, 0, 0, 0, 1);
    n = 1;
    while (active && n < 200) begin
      tick(0, 0, 0, 0, 0);
      n++;
    end
`ifdef HAT_CHOKE_FADE_EN
    exp_choke_len = 65;
`else
    exp_choke_len = 1;
`endif
    check_eq("choke_len", n, exp_choke_len);
    repeat (3) tick(0, 0, 0, 0, 0);

    // Trigger beats choke on the same tick
    tick(0, 1, 1, 15, 0);
    repeat (10) tick(0, 0, 0, 0, 0);
    tick(0, 1, 1, 9, 1);
    check_eq("prio_reload", int'(dut.gain_q), 639);
    check_eq("prio_active", int'(active), 1);
    repeat (5) tick(0, 0, 1, 0, 0);

    // Velocity 0 is ignored mid-note and from idle
    tick(0, 1, 1, 0, 0);
    check_eq("vel0_hold", int'(dut.gain_q), 639);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    check_eq("vel0_idle", int'(active), 0);

    // Velocity 1 peak
    tick(0, 1, 0, 1, 0);
    check_eq("vel1_peak", int'(dut.gain_q), 127);
    repeat (20) tick(0, 0, 0, 0, 0);

    // Reset mid-note overrides trigger and choke
    tick(0, 1, 1, 12, 0);
    repeat (30) tick(0, 0, 0, 0, 0);
    repeat (3) tick(1, 1, 1, 12, 1);
    check_eq("rst_mid_lfsr", int'(dut.lfsr_q), 'hACE1);
    check_eq("rst_mid_active", int'(active), 0);
    check_eq("rst_mid_out", int'(out), 0);
    repeat (4) tick(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 3, $urandom_range(0, 1),
           $urandom_range(0, (1 << VEL_W) - 1), $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
